// File: rtl/sync_to_count_tiled_pkg.sv
// Shared VGA 640x480 timing constants and tile geometry
// for the sync-to-count tiled position generator.
package sync_to_count_tiled_pkg;

   localparam int CNT_W  = 10;
   localparam int TILE_W = 5;

   localparam int VGA_TOTAL_COLS  = 800;
   localparam int VGA_TOTAL_ROWS  = 525;
   localparam int VGA_ACTIVE_COLS = 640;
   localparam int VGA_ACTIVE_ROWS = 480;
   localparam int VGA_TILE_SHIFT  = 5;

endpackage

// File: rtl/sync_to_count_tiled.sv
// Converts HSync/VSync into registered column/row counts,
// tile coordinates, active flag and a frame-start pulse.
module sync_to_count_tiled
   import sync_to_count_tiled_pkg::*;
#(
   parameter int TOTAL_COLS  = VGA_TOTAL_COLS,
   parameter int TOTAL_ROWS  = VGA_TOTAL_ROWS,
   parameter int ACTIVE_COLS = VGA_ACTIVE_COLS,
   parameter int ACTIVE_ROWS = VGA_ACTIVE_ROWS,
   parameter int TILE_SHIFT  = VGA_TILE_SHIFT
) (
   input  logic              i_Clk,
   input  logic              i_Rst_n,
   input  logic              i_HSync,
   input  logic              i_VSync,
   output logic              o_HSync,
   output logic              o_VSync,
   output logic [CNT_W-1:0]  o_Col_Count,
   output logic [CNT_W-1:0]  o_Row_Count,
   output logic [TILE_W-1:0] o_Col_Tile,
   output logic [TILE_W-1:0] o_Row_Tile,
   output logic              o_Active,
   output logic              o_Frame_Start
);

   localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(TOTAL_COLS - 1);
   localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(TOTAL_ROWS - 1);
   localparam logic [CNT_W-1:0] ACT_COLS = CNT_W'(ACTIVE_COLS);
   localparam logic [CNT_W-1:0] ACT_ROWS = CNT_W'(ACTIVE_ROWS);

   logic frame_evt;
   logic col_wrap;
   logic row_wrap;

   assign frame_evt = i_VSync & ~o_VSync;
   // >= keeps counts bounded even if a count ever lands out of range
   assign col_wrap  = (o_Col_Count >= COL_LAST);
   assign row_wrap  = (o_Row_Count >= ROW_LAST);

   always_ff @(posedge i_Clk) begin
      if (!i_Rst_n) begin
         o_HSync       <= 1'b0;
         o_VSync       <= 1'b0;
         o_Frame_Start <= 1'b0;
         o_Col_Count   <= '0;
         o_Row_Count   <= '0;
      end else begin
         o_HSync       <= i_HSync;
         o_VSync       <= i_VSync;
         o_Frame_Start <= frame_evt;
         if (frame_evt) begin
            o_Col_Count <= '0;
            o_Row_Count <= '0;
         end else if (col_wrap) begin
            o_Col_Count <= '0;
            o_Row_Count <= row_wrap ? '0 : o_Row_Count + 1'b1;
         end else begin
            o_Col_Count <= o_Col_Count + 1'b1;
         end
      end
   end

   assign o_Col_Tile = TILE_W'(o_Col_Count >> TILE_SHIFT);
   assign o_Row_Tile = TILE_W'(o_Row_Count >> TILE_SHIFT);
   assign o_Active   = (o_Col_Count < ACT_COLS) &&
                       (o_Row_Count < ACT_ROWS);

endmodule

// File: tb/tb_sync_to_count_tiled.sv
// Bench for sync_to_count_tiled: default VGA instance plus a
// small-frame instance, checked against a linear-position model.
module tb_sync_to_count_tiled;

   logic clk;
   logic rst_n;
   logic hs_i;
   logic vs_i;

   logic       hs_o    [2];
   logic       vs_o    [2];
   logic       fs_o    [2];
   logic       act     [2];
   logic [9:0] col_cnt [2];
   logic [9:0] row_cnt [2];
   logic [4:0] col_t   [2];
   logic [4:0] row_t   [2];

   int checks;
   int failures;

   int m_pos [2];
   bit m_hs;
   bit m_vs;
   bit m_fs;

   sync_to_count_tiled u_vga (
      .i_Clk         (clk),
      .i_Rst_n       (rst_n),
      .i_HSync       (hs_i),
      .i_VSync       (vs_i),
      .o_HSync       (hs_o[0]),
      .o_VSync       (vs_o[0]),
      .o_Col_Count   (col_cnt[0]),
      .o_Row_Count   (row_cnt[0]),
      .o_Col_Tile    (col_t[0]),
      .o_Row_Tile    (row_t[0]),
      .o_Active      (act[0]),
      .o_Frame_Start (fs_o[0])
   );

   sync_to_count_tiled #(
      .TOTAL_COLS  (50),
      .TOTAL_ROWS  (7),
      .ACTIVE_COLS (40),
      .ACTIVE_ROWS (5),
      .TILE_SHIFT  (1)
   ) u_small (
      .i_Clk         (clk),
      .i_Rst_n       (rst_n),
      .i_HSync       (hs_i),
      .i_VSync       (vs_i),
      .o_HSync       (hs_o[1]),
      .o_VSync       (vs_o[1]),
      .o_Col_Count   (col_cnt[1]),
      .o_Row_Count   (row_cnt[1]),
      .o_Col_Tile    (col_t[1]),
      .o_Row_Tile    (row_t[1]),
      .o_Active      (act[1]),
      .o_Frame_Start (fs_o[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int tc(input int i);
      return (i == 0) ? 800 : 50;
   endfunction
   function automatic int tr(input int i);
      return (i == 0) ? 525 : 7;
   endfunction
   function automatic int ac(input int i);
      return (i == 0) ? 640 : 40;
   endfunction
   function automatic int ar(input int i);
      return (i == 0) ? 480 : 5;
   endfunction
   function automatic int tsz(input int i);
      return (i == 0) ? 32 : 2;
   endfunction
   function automatic int ecol(input int i);
      return m_pos[i] % tc(i);
   endfunction
   function automatic int erow(input int i);
      return m_pos[i] / tc(i);
   endfunction

   // Model: a frame is a linear pixel index that wraps at cols*rows
   task automatic step(input bit rst, input bit h, input bit v);
      bit evt;
      rst_n = rst;
      hs_i  = h;
      vs_i  = v;
      @(posedge clk);
      if (!rst) begin
         m_pos[0] = 0;
         m_pos[1] = 0;
         m_hs = 1'b0;
         m_vs = 1'b0;
         m_fs = 1'b0;
      end else begin
         evt = v && !m_vs;
         m_fs = evt;
         for (int i = 0; i < 2; i++)
            m_pos[i] = evt ? 0 : (m_pos[i] + 1) % (tc(i) * tr(i));
         m_hs = h;
         m_vs = v;
      end
      #1;
   endtask

   task automatic test_reset();
      for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0);
      checks++;
      if (col_cnt[0] !== 10'd0 || row_cnt[0] !== 10'd0) begin
         failures++;
         $display("FAIL reset_counts got %0d,%0d want 0,0",
                  col_cnt[0], row_cnt[0]);
      end
      checks++;
      if (hs_o[0] !== 1'b0 || vs_o[0] !== 1'b0 || fs_o[0] !== 1'b0) begin
         failures++;
         $display("FAIL reset_flags got hs=%b vs=%b fs=%b want 0",
                  hs_o[0], vs_o[0], fs_o[0]);
      end
      for (int k = 1; k <= 3; k++) begin
         step(1'b1, 1'b0, 1'b0);
         checks++;
         if (col_cnt[0] !== 10'(k) || row_cnt[0] !== 10'd0 ||
             col_cnt[0] !== 10'(ecol(0))) begin
            failures++;
            $display("FAIL release_col got %0d,%0d want %0d,0",
                     col_cnt[0], row_cnt[0], k);
         end
      end
      step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      checks++;
      if (col_cnt[0] !== 10'd0 || row_cnt[0] !== 10'd0 ||
          fs_o[0] !== 1'b1 || fs_o[0] !== m_fs) begin
         failures++;
         $display("FAIL release_vsync got %0d,%0d fs=%b want 0,0 fs=1",
                  col_cnt[0], row_cnt[0], fs_o[0]);
      end
      step(1'b1, 1'b0, 1'b1);
      checks++;
      if (col_cnt[0] !== 10'd1 || fs_o[0] !== 1'b0) begin
         failures++;
         $display("FAIL release_after got col=%0d fs=%b want 1 fs=0",
                  col_cnt[0], fs_o[0]);
      end
      step(1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_frame_start();
      for (int n = 0; n < 1000 && ecol(0) != 417; n++)
         step(1'b1, 1'b0, 1'b0);
      checks++;
      if (col_cnt[0] !== 10'd417) begin
         failures++;
         $display("FAIL fs_pre_col got %0d want 417", col_cnt[0]);
      end
      step(1'b1, 1'b0, 1'b1);
      checks++;
      if (col_cnt[0] !== 10'd0 || row_cnt[0] !== 10'd0 ||
          fs_o[0] !== 1'b1) begin
         failures++;
         $display("FAIL fs_event got %0d,%0d fs=%b want 0,0 fs=1",
                  col_cnt[0], row_cnt[0], fs_o[0]);
      end
      step(1'b1, 1'b0, 1'b1);
      checks++;
      if (col_cnt[0] !== 10'd1 || row_cnt[0] !== 10'd0 ||
          fs_o[0] !== 1'b0) begin
         failures++;
         $display("FAIL fs_next got %0d,%0d fs=%b want 1,0 fs=0",
                  col_cnt[0], row_cnt[0], fs_o[0]);
      end
      step(1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_wrap();
      int r;
      for (int n = 0; n < 1000 && ecol(0) != 799; n++)
         step(1'b1, 1'b0, 1'b0);
      r = erow(0);
      checks++;
      if (col_cnt[0] !== 10'd799 || row_cnt[0] !== 10'(r)) begin
         failures++;
         $display("FAIL col_last got %0d,%0d want 799,%0d",
                  col_cnt[0], row_cnt[0], r);
      end
      step(1'b1, 1'b0, 1'b0);
      checks++;
      if (col_cnt[0] !== 10'd0 || row_cnt[0] !== 10'(r + 1)) begin
         failures++;
         $display("FAIL col_wrap got %0d,%0d want 0,%0d",
                  col_cnt[0], row_cnt[0], r + 1);
      end
      for (int n = 0; n < 400 && m_pos[1] != 349; n++)
         step(1'b1, 1'b0, 1'b0);
      checks++;
      if (col_cnt[1] !== 10'd49 || row_cnt[1] !== 10'd6) begin
         failures++;
         $display("FAIL frame_last got %0d,%0d want 49,6",
                  col_cnt[1], row_cnt[1]);
      end
      step(1'b1, 1'b0, 1'b0);
      checks++;
      if (col_cnt[1] !== 10'd0 || row_cnt[1] !== 10'd0 ||
          fs_o[1] !== 1'b0) begin
         failures++;
         $display("FAIL row_wrap got %0d,%0d fs=%b want 0,0 fs=0",
                  col_cnt[1], row_cnt[1], fs_o[1]);
      end
   endtask

   task automatic test_tile();
      step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      for (int n = 0; n < 1000 && m_pos[0] != 64; n++)
         step(1'b1, 1'b0, 1'b0);
      checks++;
      if (col_t[0] !== 5'd2 || row_t[0] !== 5'd0 || act[0] !== 1'b1) begin
         failures++;
         $display("FAIL tile_64 got %0d,%0d act=%b want 2,0 act=1",
                  col_t[0], row_t[0], act[0]);
      end
      for (int n = 0; n < 400 && m_pos[1] != 107; n++)
         step(1'b1, 1'b0, 1'b0);
      checks++;
      if (col_t[1] !== 5'd3 || row_t[1] !== 5'd1 || act[1] !== 1'b1) begin
         failures++;
         $display("FAIL tile_small got %0d,%0d act=%b want 3,1 act=1",
                  col_t[1], row_t[1], act[1]);
      end
      for (int n = 0; n < 400 && m_pos[1] != 309; n++)
         step(1'b1, 1'b0, 1'b0);
      checks++;
      if (col_t[1] !== 5'd4 || row_t[1] !== 5'd3 || act[1] !== 1'b0) begin
         failures++;
         $display("FAIL tile_blank got %0d,%0d act=%b want 4,3 act=0",
                  col_t[1], row_t[1], act[1]);
      end
      for (int n = 0; n < 1000 && m_pos[0] != 640; n++)
         step(1'b1, 1'b0, 1'b0);
      checks++;
      if (col_cnt[0] !== 10'd640 || col_t[0] !== 5'd20 ||
          act[0] !== 1'b0) begin
         failures++;
         $display("FAIL active_edge got col=%0d t=%0d act=%b want 640,20,0",
                  col_cnt[0], col_t[0], act[0]);
      end
   endtask

   task automatic test_hsync();
      bit h;
      bit prev;
      prev = hs_i;
      for (int n = 0; n < 32; n++) begin
         h = 1'($urandom_range(0, 1));
         step(1'b1, h, 1'b0);
         checks++;
         if (hs_o[0] !== h || hs_o[1] !== h || vs_o[0] !== 1'b0) begin
            failures++;
            $display("FAIL hsync_delay got %b/%b want %b (prev %b)",
                     hs_o[0], hs_o[1], h, prev);
         end
         prev = h;
      end
      step(1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_coincident();
      for (int n = 0; n < 400 && m_pos[1] != 349; n++)
         step(1'b1, 1'b0, 1'b0);
      checks++;
      if (col_cnt[1] !== 10'd49 || row_cnt[1] !== 10'd6) begin
         failures++;
         $display("FAIL coinc_pre got %0d,%0d want 49,6",
                  col_cnt[1], row_cnt[1]);
      end
      step(1'b1, 1'b0, 1'b1);
      checks++;
      if (col_cnt[1] !== 10'd0 || row_cnt[1] !== 10'd0 ||
          fs_o[1] !== 1'b1 || col_cnt[0] !== 10'd0) begin
         failures++;
         $display("FAIL coinc_evt got %0d,%0d fs=%b want 0,0 fs=1",
                  col_cnt[1], row_cnt[1], fs_o[1]);
      end
      step(1'b1, 1'b0, 1'b0);
      checks++;
      if (col_cnt[1] !== 10'd1 || row_cnt[1] !== 10'd0) begin
         failures++;
         $display("FAIL coinc_next got %0d,%0d want 1,0",
                  col_cnt[1], row_cnt[1]);
      end
   endtask

   task automatic test_random();
      bit v;
      bit h;
      bit r;
      v = 1'b0;
      for (int n = 0; n < 4000; n++) begin
         h = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 149) == 0) v = ~v;
         r = ($urandom_range(0, 599) != 0);
         step(r, h, v);
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (col_cnt[i] !== 10'(ecol(i)) ||
                row_cnt[i] !== 10'(erow(i))) begin
               failures++;
               $display("FAIL rnd_count[%0d] n=%0d got %0d,%0d want %0d,%0d",
                        i, n, col_cnt[i], row_cnt[i], ecol(i), erow(i));
            end
            checks++;
            if (col_t[i] !== 5'(ecol(i) / tsz(i)) ||
                row_t[i] !== 5'(erow(i) / tsz(i)) ||
                act[i] !== (ecol(i) < ac(i) && erow(i) < ar(i))) begin
               failures++;
               $display("FAIL rnd_tile[%0d] n=%0d got %0d,%0d act=%b",
                        i, n, col_t[i], row_t[i], act[i]);
            end
            checks++;
            if (hs_o[i] !== m_hs || vs_o[i] !== m_vs ||
                fs_o[i] !== m_fs) begin
               failures++;
               $display("FAIL rnd_flags[%0d] n=%0d got %b%b%b want %b%b%b",
                        i, n, hs_o[i], vs_o[i], fs_o[i], m_hs, m_vs, m_fs);
            end
         end
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      hs_i     = 1'b0;
      vs_i     = 1'b0;
      m_pos[0] = 0;
      m_pos[1] = 0;
      m_hs     = 1'b0;
      m_vs     = 1'b0;
      m_fs     = 1'b0;
      test_reset();
      test_frame_start();
      test_wrap();
      test_tile();
      test_hsync();
      test_coincident();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sync_to_count_tiled.md
SYNC_TO_COUNT_TILED -- requirements
Module: sync_to_count

Interface
REQ-001 TOTAL_COLS, default 800, total pixel clocks per line including blanking.
REQ-002 TOTAL_ROWS, default 525, total lines per frame including blanking.
REQ-003 ACTIVE_COLS, default 640, visible columns per line.
REQ-004 ACTIVE_ROWS, default 480, visible rows per frame.
REQ-005 TILE_SHIFT, default 5, log2 of tile edge in pixels (32 px tiles).
REQ-006 i_Clk  in  1  pixel clock; single clock domain.
REQ-007 i_Rst_n  in  1  reset, synchronous, active-low.
REQ-008 i_HSync  in  1  horizontal sync, active-high during visible columns.
REQ-009 i_VSync  in  1  vertical sync, active-high during visible rows.
REQ-010 o_HSync  out  1  i_HSync delayed one clock.
REQ-011 o_VSync  out  1  i_VSync delayed one clock.
REQ-012 o_Col_Count  out  10  current column, 0..TOTAL_COLS-1.
REQ-013 o_Row_Count  out  10  current row, 0..TOTAL_ROWS-1.
REQ-014 o_Col_Tile  out  5  o_Col_Count >> TILE_SHIFT.
REQ-015 o_Row_Tile  out  5  o_Row_Count >> TILE_SHIFT.
REQ-016 o_Active  out  1  high when o_Col_Count < ACTIVE_COLS and o_Row_Count < ACTIVE_ROWS.
REQ-017 o_Frame_Start  out  1  one-clock pulse, aligned with the first count of a new frame (counts 0,0).

Function
REQ-018 Frame-start event: i_VSync==1 and o_VSync==0 (rising edge of input VSync vs. its registered copy).
REQ-019 On frame-start event: o_Col_Count and o_Row_Count become 0 on the next clock.
REQ-020 Otherwise: o_Col_Count increments by 1 each clock.
REQ-021 Column wrap: o_Col_Count==TOTAL_COLS-1 -> next 0, and o_Row_Count increments by 1.
REQ-022 Row wrap: column wrap while o_Row_Count==TOTAL_ROWS-1 -> next row 0.
REQ-023 Frame-start event has priority over any increment or wrap in the same clock.
REQ-024 o_HSync/o_VSync registered; latency exactly 1 clock, so sync outputs stay aligned with counts.
REQ-025 o_Col_Tile, o_Row_Tile, o_Active derived combinationally from registered counts (zero added latency).
REQ-026 o_Frame_Start registered: high exactly during the clock in which counts read 0,0 after a frame-start event; low otherwise.
REQ-027 Counts never exceed TOTAL_COLS-1 / TOTAL_ROWS-1, even if input syncs are absent or irregular.
REQ-028 All counter arithmetic 10-bit unsigned; parameters up to 1023.

Reset
REQ-029 While i_Rst_n==0 at a clock edge: counts 0, o_HSync 0, o_VSync 0, o_Frame_Start 0.
REQ-030 First clock after release: if i_VSync==1, a frame-start event occurs (registered VSync is 0), counts remain 0, o_Frame_Start pulses.
REQ-031 Reset mid-frame abandons the current position; counting restarts from 0,0.

Structure
REQ-032 Shared package holds default VGA timing constants (800/525/640/480) and the tile shift (5).
REQ-033 Single module; no sub-module; edge detection and counters inline.

Verification
REQ-034 Reset held 3 clocks, i_VSync=0 -> counts 0, syncs 0, o_Frame_Start 0; after release col counts 1,2,3.
REQ-035 i_VSync 0->1 with col at 417 -> next clock counts 0,0, o_Frame_Start=1; following clock col=1, o_Frame_Start=0.
REQ-036 Free-run from 0,0, syncs held 0 -> col 799 wraps to 0 and row 0->1; at row 524/col 799 -> 0,0.
REQ-037 col=64,row=96 -> o_Col_Tile=2, o_Row_Tile=3, o_Active=1; col=640,row=10 -> o_Active=0.
REQ-038 i_HSync toggled -> o_HSync matches input delayed exactly 1 clock.
REQ-039 Frame-start event coincident with col 799/row 524 -> next counts 0,0, no extra row increment.
